// File: rtl/cla_nibble_seq_adder_pkg.sv
// ============================================================================
// Module : cla_nibble_seq_adder_pkg
// Brief  : State encodings and sizing helpers for the nibble-serial CLA adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cla_nibble_seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nibble_count(input int width);
        return width / 4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_nibble_seq_adder_cla4.sv
// ============================================================================
// Module : cla_nibble_seq_adder_cla4
// Brief  : Combinational 4-bit carry-lookahead slice (sum plus carries 4..1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_nibble_seq_adder_cla4
    import cla_nibble_seq_adder_pkg::*;
(
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic [4:1] carry
);

    logic [3:0] gen;
    logic [3:0] prop;

    assign gen  = in1 & in2;
    assign prop = in1 ^ in2;

    // Every carry is flattened from generate/propagate terms, no ripple.
    assign carry[1] = gen[0] | (prop[0] & c_in);
    assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_in);
    assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & c_in);
    assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                    | (prop[3] & prop[2] & prop[1] & gen[0])
                    | (prop[3] & prop[2] & prop[1] & prop[0] & c_in);

    assign sum = prop ^ {carry[3:1], c_in};

endmodule

`default_nettype wire

// File: rtl/cla_nibble_seq_adder.sv
// ============================================================================
// Module : cla_nibble_seq_adder
// Brief  : WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per
//          clock, LSB first. Optional signed overflow via SEQ_ADD_OVF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_nibble_seq_adder
    import cla_nibble_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_width_check
        $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    logic [3:0]       slice_sum;
    logic [4:1]       slice_carry;

    // Operands shift right each RUN cycle, so the active nibble is always [3:0].
    cla_nibble_seq_adder_cla4 u_slice (
        .in1   (a_reg[3:0]),
        .in2   (b_reg[3:0]),
        .c_in  (carry_reg),
        .sum   (slice_sum),
        .carry (slice_carry)
    );

`ifdef SEQ_ADD_OVF_EN
    logic unused_carry;
    assign unused_carry = ^slice_carry[2:1];
`else
    logic unused_carry;
    assign unused_carry = ^slice_carry[3:1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
`ifdef SEQ_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        a_reg     <= in1;
                        b_reg     <= in2;
                        carry_reg <= c_in;
                        idx       <= '0;
                        sum       <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    // Result nibbles enter at the MSB end and walk down.
                    sum       <= {slice_sum, sum[WIDTH-1:4]};
                    carry_reg <= slice_carry[4];
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        c_out <= slice_carry[4];
                        idx   <= '0;
`ifdef SEQ_ADD_OVF_EN
                        ovf   <= slice_carry[3] ^ slice_carry[4];
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cla_nibble_seq_adder.sv
// ============================================================================
// Module : tb_cla_nibble_seq_adder
// Brief  : Directed self-checking bench for the nibble-serial CLA adder
//          (WIDTH=16 and WIDTH=8 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cla_nibble_seq_adder;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;

    logic        start8;
    logic [7:0]  in1_8;
    logic [7:0]  in2_8;
    logic        c_in8;
    logic        busy8;
    logic        done8;
    logic [7:0]  sum8;
    logic        c_out8;

`ifdef SEQ_ADD_OVF_EN
    logic        ovf;
    logic        ovf8;
`endif

    int checks;
    int failures;

    cla_nibble_seq_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SEQ_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    cla_nibble_seq_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .in1   (in1_8),
        .in2   (in2_8),
        .c_in  (c_in8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .c_out (c_out8)
`ifdef SEQ_ADD_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_add16(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic [15:0] exp_s, input logic exp_c,
                            input logic exp_v);
        int edges;
        int busy_cnt;
        @(negedge clk);
        in1 = a; in2 = b; c_in = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0; busy_cnt = 0;
        while (!done && edges < 16) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            edges++;
        end
        check_value({tag, "_latency"}, edges, 4);
        check_value({tag, "_busy_cycles"}, busy_cnt, 4);
        check_value({tag, "_sum"}, sum, exp_s);
        check_value({tag, "_c_out"}, c_out, exp_c);
`ifdef SEQ_ADD_OVF_EN
        check_value({tag, "_ovf"}, ovf, exp_v);
`else
        if (exp_v === 1'bx) $display("note: unexpected x in expectation for %s", tag);
`endif
        @(posedge clk); #1;
        check_value({tag, "_done_pulse"}, done, 0);
        check_value({tag, "_sum_held"}, sum, exp_s);
    endtask

    task automatic do_add8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic [7:0] exp_s, input logic exp_c,
                           input logic exp_v);
        int edges;
        @(negedge clk);
        in1_8 = a; in2_8 = b; c_in8 = ci; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 0;
        while (!done8 && edges < 16) begin
            @(posedge clk); #1;
            edges++;
        end
        check_value({tag, "_latency"}, edges, 2);
        check_value({tag, "_sum"}, sum8, exp_s);
        check_value({tag, "_c_out"}, c_out8, exp_c);
`ifdef SEQ_ADD_OVF_EN
        check_value({tag, "_ovf"}, ovf8, exp_v);
`else
        if (exp_v === 1'bx) $display("note: unexpected x in expectation for %s", tag);
`endif
    endtask

    initial begin
        int edges;
        int done_cnt;
        checks = 0; failures = 0;
        rst_n = 1'b0;
        start = 1'b0; in1 = '0; in2 = '0; c_in = 1'b0;
        start8 = 1'b0; in1_8 = '0; in2_8 = '0; c_in8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_sum", sum, 0);
        check_value("rst_c_out", c_out, 0);
        check_value("rst8_sum", sum8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic arithmetic, carry ripple and overflow corners
        do_add16("t1", 16'h0004, 16'h0004, 1'b0, 16'h0008, 1'b0, 1'b0);
        do_add16("t2a", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        do_add16("t2b", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_add16("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_add16("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_add16("t3c", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        do_add16("t3d", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Start and operand changes during RUN are ignored
        @(negedge clk);
        in1 = 16'h0010; in2 = 16'h0020; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; in1 = 16'hAAAA; in2 = 16'h5555;
        @(posedge clk); #1;
        start = 1'b0; in1 = 16'hFFFF;
        edges = 2;
        while (!done && edges < 16) begin
            @(posedge clk); #1;
            edges++;
        end
        check_value("t4_latency", edges, 4);
        check_value("t4_sum", sum, 16'h0030);
        check_value("t4_c_out", c_out, 0);
        done_cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check_value("t4_extra_done", done_cnt, 0);
        check_value("t4_idle_busy", busy, 0);

        // Back-to-back issue with start held across DONE
        @(negedge clk);
        in1 = 16'h0001; in2 = 16'h0002; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        in1 = 16'h0100; in2 = 16'h0200;
        edges = 0;
        while (!done && edges < 16) begin
            @(posedge clk); #1;
            edges++;
        end
        check_value("t5_first_latency", edges, 4);
        check_value("t5_first_sum", sum, 16'h0003);
        @(posedge clk); #1;
        start = 1'b0;
        check_value("t5_rerun_busy", busy, 1);
        check_value("t5_rerun_done", done, 0);
        edges = 1;
        while (!done && edges < 16) begin
            @(posedge clk); #1;
            edges++;
        end
        check_value("t5_gap", edges, 5);
        check_value("t5_second_sum", sum, 16'h0300);
        check_value("t5_second_c_out", c_out, 0);

        // Asynchronous reset mid-RUN aborts with no done
        do_add16("t6pre", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        in1 = 16'h1111; in2 = 16'h1111; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check_value("t6_partial_sum", sum, 16'h2200);
        rst_n = 1'b0;
        #1;
        check_value("t6_rst_busy", busy, 0);
        check_value("t6_rst_done", done, 0);
        check_value("t6_rst_sum", sum, 0);
        check_value("t6_rst_c_out", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check_value("t6_no_done", done_cnt, 0);
        do_add16("t6post", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

        // Narrow instance
        do_add8("w8a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_add8("w8b", 8'h12, 8'h43, 1'b1, 8'h56, 1'b0, 1'b0);
        do_add8("w8c", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
